// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the hart data port. Word-aligned SRAM model
//   with byte-lane masking and a fixed access latency. One request is in
//   flight at a time. While a request is pending, new requests are ignored.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the array
//   LATENCY      cycles from the accept edge to the response (>= 1)
//   BASE_ADDR    byte address mapped to word 0
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_req_addr   byte address; bits [1:0] ignored
//   i_req_ren    read request
//   i_req_wen    write request
//   i_req_wdata  write data, already lane-shifted by the requester
//   i_req_mask   byte-lane enables; bit n covers bits [8n+7:8n]
//   o_req_ready  request can be accepted this cycle
//   o_res_valid  one-cycle completion pulse
//   o_res_rdata  read data (lanes with mask=0 read as 8'h00)
//   o_res_err    request faulted (ren&wen, or index out of range)
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_req_ready,
  output logic        o_res_valid,
  output logic [31:0] o_res_rdata,
  output logic        o_res_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            accept;
  logic            enter_resp;

  logic [31:0]     l_addr;
  logic            l_ren;
  logic            l_wen;
  logic [31:0]     l_wdata;
  logic [3:0]      l_mask;

  logic [31:0]     t_addr;
  logic            t_ren;
  logic            t_wen;
  logic [31:0]     t_wdata;
  logic [3:0]      t_mask;
  logic [31:0]     t_off;
  logic [31:0]     t_widx;
  logic            t_err;
  logic [31:0]     t_lanes;
  logic            do_write;

  logic [31:0]     mem [DEPTH_WORDS];

  assign accept      = (state == IDLE) && (i_req_ren || i_req_wen);
  assign o_req_ready = (state == IDLE);
  assign o_res_valid = (state == RESP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter is "done" on the edge where it decrements to zero, so BUSY
  // lasts LATENCY-1 cycles and LATENCY=1 goes straight from IDLE to RESP.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CW'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      l_addr  <= '0;
      l_ren   <= 1'b0;
      l_wen   <= 1'b0;
      l_wdata <= '0;
      l_mask  <= '0;
    end else if (accept) begin
      l_addr  <= i_req_addr;
      l_ren   <= i_req_ren;
      l_wen   <= i_req_wen;
      l_wdata <= i_req_wdata;
      l_mask  <= i_req_mask;
    end
  end

  // The access completes on the accept edge itself when LATENCY=1, so the
  // transaction is taken from the live inputs in IDLE and from the latch
  // otherwise.
  always_comb begin
    if (state == IDLE) begin
      t_addr  = i_req_addr;
      t_ren   = i_req_ren;
      t_wen   = i_req_wen;
      t_wdata = i_req_wdata;
      t_mask  = i_req_mask;
    end else begin
      t_addr  = l_addr;
      t_ren   = l_ren;
      t_wen   = l_wen;
      t_wdata = l_wdata;
      t_mask  = l_mask;
    end
  end

  // Addresses below BASE_ADDR wrap to a huge index and fault as out of range.
  assign t_off   = t_addr - BASE_ADDR;
  assign t_widx  = t_off >> 2;
  assign t_err   = (t_ren && t_wen) || (t_widx >= DEPTH_WORDS);
  assign t_lanes = {{8{t_mask[3]}}, {8{t_mask[2]}}, {8{t_mask[1]}}, {8{t_mask[0]}}};
  assign do_write = enter_resp && t_wen && !t_err && !i_rst;

  always_ff @(posedge i_clk) begin
    if (do_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (t_mask[b]) begin
          mem[t_widx[AW-1:0]][8*b +: 8] <= t_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_res_rdata <= '0;
      o_res_err   <= 1'b0;
    end else if (enter_resp) begin
      o_res_err <= t_err;
      if (t_ren && !t_err) begin
        o_res_rdata <= mem[t_widx[AW-1:0]] & t_lanes;
      end else begin
        o_res_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses the default parameters
// (LATENCY=2, DEPTH_WORDS=1024, BASE_ADDR=0). Instance 1 uses LATENCY=1,
// DEPTH_WORDS=64, BASE_ADDR=0x100. Both share the clock and reset, and
// request valids are steered by sel.
module tb_dmem_responder;

  localparam int          L0 = 2;
  localparam int          L1 = 1;
  localparam longint      D0 = 1024;
  localparam longint      D1 = 64;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam logic [31:0] B1 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] addr, wdata;
  logic        ren, wen;
  logic [3:0]  mask;

  logic        rdy0, vld0, err0, rdy1, vld1, err1;
  logic [31:0] rd0, rd1;
  logic        rdy, vld, err;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mm [bit [32:0]];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req_addr(addr), .i_req_ren(ren & ~sel),
    .i_req_wen(wen & ~sel), .i_req_wdata(wdata), .i_req_mask(mask),
    .o_req_ready(rdy0), .o_res_valid(vld0), .o_res_rdata(rd0), .o_res_err(err0)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1), .BASE_ADDR(32'h0000_0100)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_addr(addr), .i_req_ren(ren & sel),
    .i_req_wen(wen & sel), .i_req_wdata(wdata), .i_req_mask(mask),
    .o_req_ready(rdy1), .o_res_valid(vld1), .o_res_rdata(rd1), .o_res_err(err1)
  );

  assign rdy   = sel ? rdy1 : rdy0;
  assign vld   = sel ? vld1 : vld0;
  assign err   = sel ? err1 : err0;
  assign rdata = sel ? rd1  : rd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference memory: a sparse word map keyed by {instance, word index}.
  function automatic void model_op(input bit s, input logic [31:0] a, input bit r, input bit w,
                                   input logic [31:0] d, input logic [3:0] m,
                                   output logic [31:0] exp_rd, output bit exp_err,
                                   output bit known);
    logic [31:0] base, idx, word;
    bit [32:0]   key;
    longint      depth;
    base    = s ? B1 : B0;
    depth   = s ? D1 : D0;
    idx     = (a - base) / 32'd4;
    key     = {s, idx};
    exp_rd  = 32'h0;
    known   = 1'b1;
    exp_err = (r && w) || (longint'(idx) >= depth);
    if (exp_err) return;
    if (w) begin
      word = mm.exists(key) ? mm[key] : 32'h0;
      for (int b = 0; b < 4; b++) if (m[b]) word[8*b +: 8] = d[8*b +: 8];
      if (mm.exists(key) || m == 4'hF) mm[key] = word;
    end else if (r) begin
      if (mm.exists(key)) begin
        word = mm[key];
        for (int b = 0; b < 4; b++) exp_rd[8*b +: 8] = m[b] ? word[8*b +: 8] : 8'h00;
      end else begin
        known = (m == 4'h0);
      end
    end
  endfunction

  task automatic xact(input bit s, input logic [31:0] a, input bit r, input bit w,
                      input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp_rd,
                      input bit exp_err, input bit chk_rd, input string nm);
    int n;
    @(negedge clk);
    sel = s; addr = a; ren = r; wen = w; wdata = d; mask = m;
    chk({nm, "_ready"}, 32'(rdy), 32'd1);
    @(negedge clk);
    ren = 1'b0; wen = 1'b0;
    n = 1;
    while (!vld && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), s ? 32'(L1) : 32'(L0));
    chk({nm, "_valid"}, 32'(vld), 32'd1);
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    if (chk_rd) chk({nm, "_rdata"}, rdata, exp_rd);
  endtask

  // ren held high: valid expected at sample i = lat + k*(lat+1), ready
  // again one cycle after each valid.
  task automatic burst(input bit s, input int lat, input logic [31:0] a,
                       input logic [31:0] exp_rd, input int n, input string nm);
    bit ev, er;
    @(negedge clk);
    sel = s; addr = a; mask = 4'hF; wen = 1'b0; ren = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      ev = (i >= lat) && (((i - lat) % (lat + 1)) == 0);
      chk($sformatf("%s_valid_%0d", nm, i), 32'(vld), 32'(ev));
      if (i > lat) begin
        er = (((i - lat - 1) % (lat + 1)) == 0);
        chk($sformatf("%s_ready_%0d", nm, i), 32'(rdy), 32'(er));
      end
      if (ev) chk($sformatf("%s_rdata_%0d", nm, i), rdata, exp_rd);
    end
    ren = 1'b0;
    repeat (lat + 2) @(negedge clk);
  endtask

  typedef struct {
    bit          s;
    logic [31:0] a;
    bit          r;
    bit          w;
    logic [31:0] d;
    logic [3:0]  m;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] er, a, d;
    bit          ee, kn, r, w;
    logic [3:0]  m;
    int          pick;

    rst = 1'b1; sel = 1'b0; addr = '0; wdata = '0; ren = 1'b0; wen = 1'b0; mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(rdy0), 32'd1);
    chk("rst_valid0", 32'(vld0), 32'd0);
    chk("rst_rdata0", rd0, 32'd0);
    chk("rst_err0",   32'(err0), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd1);
    chk("rst_valid1", 32'(vld1), 32'd0);
    chk("rst_rdata1", rd1, 32'd0);
    chk("rst_err1",   32'(err1), 32'd0);
    rst = 1'b0;

    //            s   addr          r  w  wdata          mask     exp_rd         err
    vecs.push_back('{0, 32'h0000_0010, 0, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000, 0});
    vecs.push_back('{0, 32'h0000_0010, 1, 0, 32'h0,        4'b1111, 32'hDEAD_BEEF, 0});
    vecs.push_back('{0, 32'h0000_0012, 0, 1, 32'h00AA_0000, 4'b0100, 32'h0000_0000, 0});
    vecs.push_back('{0, 32'h0000_0010, 1, 0, 32'h0,        4'b1111, 32'hDEAA_BEEF, 0});
    vecs.push_back('{0, 32'h0000_0010, 1, 0, 32'h0,        4'b1100, 32'hDEAA_0000, 0});
    vecs.push_back('{0, 32'h0000_0013, 1, 0, 32'h0,        4'b0011, 32'h0000_BEEF, 0});
    vecs.push_back('{0, 32'h0000_1000, 1, 0, 32'h0,        4'b1111, 32'h0000_0000, 1});
    vecs.push_back('{0, 32'h0000_0FFC, 0, 1, 32'h0BAD_F00D, 4'b1111, 32'h0000_0000, 0});
    vecs.push_back('{0, 32'h0000_0FFC, 1, 0, 32'h0,        4'b1111, 32'h0BAD_F00D, 0});
    vecs.push_back('{0, 32'h0000_0010, 1, 1, 32'h1111_1111, 4'b1111, 32'h0000_0000, 1});
    vecs.push_back('{0, 32'h0000_0010, 1, 0, 32'h0,        4'b1111, 32'hDEAA_BEEF, 0});
    vecs.push_back('{0, 32'h0000_0000, 0, 1, 32'h0102_0304, 4'b1111, 32'h0000_0000, 0});
    vecs.push_back('{0, 32'h0000_1000, 0, 1, 32'h5555_5555, 4'b1111, 32'h0000_0000, 1});
    vecs.push_back('{0, 32'h0000_0000, 1, 0, 32'h0,        4'b1111, 32'h0102_0304, 0});
    vecs.push_back('{0, 32'h0000_0020, 0, 1, 32'hCAFE_F00D, 4'b1111, 32'h0000_0000, 0});
    vecs.push_back('{0, 32'h0000_0020, 0, 1, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0000, 0});
    vecs.push_back('{0, 32'h0000_0020, 1, 0, 32'h0,        4'b1111, 32'hCAFE_F00D, 0});
    vecs.push_back('{1, 32'h0000_0100, 0, 1, 32'hA5A5_A5A5, 4'b1111, 32'h0000_0000, 0});
    vecs.push_back('{1, 32'h0000_0100, 1, 0, 32'h0,        4'b1111, 32'hA5A5_A5A5, 0});
    vecs.push_back('{1, 32'h0000_00FC, 1, 0, 32'h0,        4'b1111, 32'h0000_0000, 1});
    vecs.push_back('{1, 32'h0000_0200, 1, 0, 32'h0,        4'b1111, 32'h0000_0000, 1});
    vecs.push_back('{1, 32'h0000_01FC, 0, 1, 32'h1234_5678, 4'b1111, 32'h0000_0000, 0});
    vecs.push_back('{1, 32'h0000_01FC, 1, 0, 32'h0,        4'b0110, 32'h0034_5600, 0});

    foreach (vecs[k]) begin
      model_op(vecs[k].s, vecs[k].a, vecs[k].r, vecs[k].w, vecs[k].d, vecs[k].m, er, ee, kn);
      xact(vecs[k].s, vecs[k].a, vecs[k].r, vecs[k].w, vecs[k].d, vecs[k].m,
           vecs[k].exp_rd, vecs[k].exp_err, 1'b1, $sformatf("vec%0d", k));
    end

    burst(1'b0, L0, 32'h0000_0010, 32'hDEAA_BEEF, 15, "burst0");
    burst(1'b1, L1, 32'h0000_0100, 32'hA5A5_A5A5, 10, "burst1");

    // Reset while a write sits in BUSY: the write must be dropped.
    @(negedge clk);
    sel = 1'b0; addr = 32'h0000_0020; wdata = 32'h1234_5678; mask = 4'hF; wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
    chk("abort_busy", 32'(rdy0), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(rdy0), 32'd1);
    chk("abort_valid", 32'(vld0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort_novalid_%0d", i), 32'(vld0), 32'd0);
    end
    xact(1'b0, 32'h0000_0020, 1'b1, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1, "abort_rd");

    // Randomised traffic against the reference map; words 0..15 seeded first.
    for (int s = 0; s < 2; s++) begin
      for (int wi = 0; wi < 16; wi++) begin
        a = (s ? B1 : B0) + 32'(wi * 4);
        d = $urandom;
        model_op(s[0], a, 1'b0, 1'b1, d, 4'hF, er, ee, kn);
        xact(s[0], a, 1'b0, 1'b1, d, 4'hF, er, ee, kn, $sformatf("seed%0d_%0d", s, wi));
      end
      for (int k = 0; k < 40; k++) begin
        pick = int'($urandom_range(0, 9));
        a = (s ? B1 : B0) + 32'($urandom_range(0, 63));
        if (pick == 0) a = (s ? B1 : B0) + 32'((s ? D1 : D0) * 4) + 32'($urandom_range(0, 255));
        if (pick == 1) a = (s ? B1 : B0) - 32'($urandom_range(1, 64));
        r = (pick inside {2, 3, 4, 5}) || (pick == 9);
        w = !(pick inside {2, 3, 4, 5});
        m = 4'($urandom);
        d = $urandom;
        model_op(s[0], a, r, w, d, m, er, ee, kn);
        xact(s[0], a, r, w, d, m, er, ee, kn, $sformatf("rnd%0d_%0d", s, k));
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
